// File: rtl/serving_host_pkg.sv
// Shared opcodes, response codes and parser states for the serving host loader.
package serving_host_pkg;

    localparam logic [7:0] OP_W = 8'h57;
    localparam logic [7:0] OP_R = 8'h52;
    localparam logic [7:0] OP_H = 8'h48;
    localparam logic [7:0] OP_G = 8'h47;

    localparam logic [7:0] RSP_OK  = 8'h4B;
    localparam logic [7:0] RSP_ERR = 8'h45;
    localparam logic [7:0] RSP_UNK = 8'h3F;
    localparam logic [7:0] RSP_TMO = 8'hEE;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADR,
        ST_DAT,
        ST_SEL,
        ST_BUS,
        ST_RESP
    } state_t;

endpackage

// File: rtl/serving_host_txser.sv
// Response serializer: emits 1..4 bytes of a loaded word, LSB first, over valid/ready.
module serving_host_txser (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_load,
    input  logic [31:0] i_word,
    input  logic [1:0]  i_last,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    output logic        o_done
);

    logic [31:0] word;
    logic [1:0]  last;
    logic [1:0]  idx;
    logic [1:0]  next_idx;

    assign next_idx = idx + 2'd1;
    assign o_done   = o_tx_valid & i_tx_ready & (idx == last);

    // Data only moves on a completed handshake, so backpressure never drops a byte.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            word       <= '0;
            last       <= '0;
            idx        <= '0;
            o_tx_data  <= '0;
            o_tx_valid <= 1'b0;
        end else if (i_load) begin
            word       <= i_word;
            last       <= i_last;
            idx        <= '0;
            o_tx_data  <= i_word[7:0];
            o_tx_valid <= 1'b1;
        end else if (o_tx_valid && i_tx_ready) begin
            if (idx == last) begin
                o_tx_valid <= 1'b0;
            end else begin
                idx       <= next_idx;
                o_tx_data <= word[{next_idx, 3'b000} +: 8];
            end
        end
    end

endmodule

// File: rtl/serving_host_loader.sv
// Host command engine: parses bytes, drives serving's bridge port and owns the RAM mux / CPU reset.
module serving_host_loader
    import serving_host_pkg::*;
#(
    parameter int TIMEOUT   = 1024,
    parameter bit BOOT_HOLD = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    output logic        o_rx_ready,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    output logic [9:0]  o_adr_brg,
    output logic [31:0] o_data_brg,
    output logic        o_stb_brg,
    output logic        o_wen_brg,
    output logic [3:0]  o_sel_brg,
    input  logic [31:0] i_rdt_brg,
    input  logic        i_ack_brg,
    output logic        o_sel_wadr,
    output logic        o_sel_wdata,
    output logic        o_sel_radr,
    output logic        o_sel_wen,
    output logic        o_sel_rdata,
    output logic        o_cpu_rst,
    output logic        o_host_mode
);

    localparam int TW = $clog2(TIMEOUT + 1);

    state_t      state;
    logic [1:0]  byte_cnt;
    logic        is_write;
    logic        host_mode;
    logic [TW-1:0] tmo_cnt;
    logic        resp_load;
    logic [31:0] resp_word;
    logic [1:0]  resp_last;
    logic        resp_done;
    logic        rx_fire;

    assign o_rx_ready  = (state == ST_IDLE) || (state == ST_ADR) ||
                         (state == ST_DAT)  || (state == ST_SEL);
    assign rx_fire     = i_rx_valid & o_rx_ready;

    assign o_host_mode = host_mode;
    assign o_sel_wadr  = host_mode;
    assign o_sel_wdata = host_mode;
    assign o_sel_radr  = host_mode;
    assign o_sel_wen   = host_mode;
    assign o_sel_rdata = ~host_mode;
    assign o_cpu_rst   = i_rst | host_mode;

    // Bus fields are only written while parsing, so they stay frozen for the whole strobe.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= ST_IDLE;
            byte_cnt   <= '0;
            is_write   <= 1'b0;
            host_mode  <= BOOT_HOLD;
            tmo_cnt    <= '0;
            o_adr_brg  <= '0;
            o_data_brg <= '0;
            o_sel_brg  <= '0;
            o_stb_brg  <= 1'b0;
            o_wen_brg  <= 1'b0;
            resp_load  <= 1'b0;
            resp_word  <= '0;
            resp_last  <= '0;
        end else begin
            resp_load <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rx_fire) begin
                        byte_cnt  <= '0;
                        resp_last <= '0;
                        case (i_rx_data)
                            OP_W: begin
                                is_write <= 1'b1;
                                state    <= ST_ADR;
                            end
                            OP_R: begin
                                is_write <= 1'b0;
                                state    <= ST_ADR;
                            end
                            OP_H, OP_G: begin
                                host_mode <= (i_rx_data == OP_H);
                                resp_word <= {24'h0, RSP_OK};
                                resp_load <= 1'b1;
                                state     <= ST_RESP;
                            end
                            default: begin
                                resp_word <= {24'h0, RSP_UNK};
                                resp_load <= 1'b1;
                                state     <= ST_RESP;
                            end
                        endcase
                    end
                end
                ST_ADR: begin
                    if (rx_fire) begin
                        if (byte_cnt == 2'd0) begin
                            o_adr_brg[7:0] <= i_rx_data;
                            byte_cnt       <= 2'd1;
                        end else begin
                            o_adr_brg[9:8] <= i_rx_data[1:0];
                            byte_cnt       <= 2'd0;
                            state          <= is_write ? ST_DAT : ST_SEL;
                        end
                    end
                end
                ST_DAT: begin
                    if (rx_fire) begin
                        o_data_brg[{byte_cnt, 3'b000} +: 8] <= i_rx_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3)
                            state <= ST_SEL;
                    end
                end
                ST_SEL: begin
                    if (rx_fire) begin
                        o_sel_brg <= i_rx_data[3:0];
                        if (host_mode) begin
                            o_stb_brg <= 1'b1;
                            o_wen_brg <= is_write;
                            tmo_cnt   <= '0;
                            state     <= ST_BUS;
                        end else begin
                            resp_word <= {24'h0, RSP_ERR};
                            resp_last <= '0;
                            resp_load <= 1'b1;
                            state     <= ST_RESP;
                        end
                    end
                end
                ST_BUS: begin
                    if (i_ack_brg) begin
                        o_stb_brg <= 1'b0;
                        o_wen_brg <= 1'b0;
                        resp_word <= is_write ? {24'h0, RSP_OK} : i_rdt_brg;
                        resp_last <= is_write ? 2'd0 : 2'd3;
                        resp_load <= 1'b1;
                        state     <= ST_RESP;
                    end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                        o_stb_brg <= 1'b0;
                        o_wen_brg <= 1'b0;
                        resp_word <= {24'h0, RSP_TMO};
                        resp_last <= '0;
                        resp_load <= 1'b1;
                        state     <= ST_RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                ST_RESP: begin
                    if (resp_done)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    serving_host_txser u_txser (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (resp_load),
        .i_word     (resp_word),
        .i_last     (resp_last),
        .o_tx_data  (o_tx_data),
        .o_tx_valid (o_tx_valid),
        .i_tx_ready (i_tx_ready),
        .o_done     (resp_done)
    );

endmodule

// File: tb/tb_serving_host_loader.sv
// Directed bench for serving_host_loader with a response-byte scoreboard and a scripted bridge slave.
module tb_serving_host_loader;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [7:0]  i_rx_data = '0;
    logic        i_rx_valid = 1'b0;
    logic        o_rx_ready;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid;
    logic        i_tx_ready = 1'b0;
    logic [9:0]  o_adr_brg;
    logic [31:0] o_data_brg;
    logic        o_stb_brg;
    logic        o_wen_brg;
    logic [3:0]  o_sel_brg;
    logic [31:0] i_rdt_brg = 32'hDEADBEEF;
    logic        i_ack_brg = 1'b0;
    logic        o_sel_wadr, o_sel_wdata, o_sel_radr, o_sel_wen, o_sel_rdata;
    logic        o_cpu_rst, o_host_mode;

    int n_cmp = 0;
    int n_err = 0;
    int stb_cycles = 0;
    logic [7:0] sb[$];

    serving_host_loader #(.TIMEOUT(16), .BOOT_HOLD(1'b1)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid), .o_rx_ready(o_rx_ready),
        .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready),
        .o_adr_brg(o_adr_brg), .o_data_brg(o_data_brg), .o_stb_brg(o_stb_brg),
        .o_wen_brg(o_wen_brg), .o_sel_brg(o_sel_brg),
        .i_rdt_brg(i_rdt_brg), .i_ack_brg(i_ack_brg),
        .o_sel_wadr(o_sel_wadr), .o_sel_wdata(o_sel_wdata), .o_sel_radr(o_sel_radr),
        .o_sel_wen(o_sel_wen), .o_sel_rdata(o_sel_rdata),
        .o_cpu_rst(o_cpu_rst), .o_host_mode(o_host_mode)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) if (o_stb_brg) stb_cycles <= stb_cycles + 1;

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge i_clk);
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        while (!o_rx_ready && n < 100) begin
            @(negedge i_clk);
            n++;
        end
        if (!o_rx_ready) check("rx_ready_wait", {63'd0, o_rx_ready}, 64'd1);
        @(posedge i_clk);
        #1 i_rx_valid = 1'b0;
    endtask

    task automatic recv_byte(input int hold);
        int n = 0;
        logic [7:0] first;
        logic [7:0] exp;
        @(negedge i_clk);
        while (!o_tx_valid && n < 200) begin
            @(negedge i_clk);
            n++;
        end
        check("tx_valid_wait", {63'd0, o_tx_valid}, 64'd1);
        first = o_tx_data;
        for (int i = 0; i < hold; i++) begin
            @(negedge i_clk);
            check("tx_hold_stable", {55'd0, o_tx_valid, o_tx_data}, {55'd0, 1'b1, first});
        end
        if (sb.size() == 0) begin
            check("scoreboard_empty", 64'd1, 64'd0);
            exp = 8'h00;
        end else begin
            exp = sb.pop_front();
        end
        check("tx_byte", {56'd0, o_tx_data}, {56'd0, exp});
        i_tx_ready = 1'b1;
        @(posedge i_clk);
        #1 i_tx_ready = 1'b0;
    endtask

    task automatic recv_all(input int hold);
        while (sb.size() > 0) recv_byte(hold);
    endtask

    task automatic wait_stb();
        int n = 0;
        @(negedge i_clk);
        while (!o_stb_brg && n < 50) begin
            @(negedge i_clk);
            n++;
        end
        check("stb_wait", {63'd0, o_stb_brg}, 64'd1);
    endtask

    task automatic pulse_ack(input logic [31:0] rdt);
        @(negedge i_clk);
        i_ack_brg = 1'b1;
        i_rdt_brg = rdt;
        @(posedge i_clk);
        #1 i_ack_brg = 1'b0;
        i_rdt_brg = 32'hDEADBEEF;
        @(negedge i_clk);
        check("stb_drop_after_ack", {63'd0, o_stb_brg}, 64'd0);
    endtask

    initial begin
        int stb_before;
        int cnt;
        logic [47:0] bus_exp;

        // Reset state with the CPU held
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        check("rst_cpu_rst", {63'd0, o_cpu_rst}, 64'd1);
        check("rst_sel_wadr", {63'd0, o_sel_wadr}, 64'd1);
        check("rst_sel_rdata", {63'd0, o_sel_rdata}, 64'd0);
        check("rst_stb_wen_txv", {61'd0, o_stb_brg, o_wen_brg, o_tx_valid}, 64'd0);
        check("rst_rx_ready", {63'd0, o_rx_ready}, 64'd1);
        check("rst_bus_regs", {10'd0, o_adr_brg, o_data_brg, o_sel_brg, o_tx_data}, 64'd0);
        i_rst = 1'b0;
        @(negedge i_clk);
        check("boot_host_mode", {61'd0, o_host_mode, o_cpu_rst, o_sel_wdata}, {61'd0, 3'b111});

        // Release the CPU
        send_byte(8'h47); sb.push_back(8'h4B); recv_all(0);
        check("g_cpu_mode", {60'd0, o_cpu_rst, o_sel_rdata, o_host_mode, o_sel_wen}, {60'd0, 4'b0100});

        // Write in CPU mode must never touch the bus
        stb_before = stb_cycles;
        send_byte(8'h57); send_byte(8'h10); send_byte(8'h00);
        send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12); send_byte(8'h0F);
        sb.push_back(8'h45); recv_all(0);
        check("cpu_mode_no_stb", 64'(stb_cycles), 64'(stb_before));

        // Unknown opcode
        send_byte(8'h00); sb.push_back(8'h3F); recv_all(0);

        // Back to host mode
        send_byte(8'h48); sb.push_back(8'h4B); recv_all(0);
        check("h_host_mode", {62'd0, o_host_mode, o_cpu_rst}, {62'd0, 2'b11});

        // Write with a slow ack
        send_byte(8'h57); send_byte(8'h10); send_byte(8'h00);
        send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12); send_byte(8'h0F);
        wait_stb();
        bus_exp = {1'b1, 1'b1, 10'h010, 32'h12345678, 4'hF};
        check("w_bus_fields", {16'd0, o_stb_brg, o_wen_brg, o_adr_brg, o_data_brg, o_sel_brg}, {16'd0, bus_exp});
        for (int i = 0; i < 8; i++) begin
            @(negedge i_clk);
            check("w_bus_stable", {16'd0, o_stb_brg, o_wen_brg, o_adr_brg, o_data_brg, o_sel_brg}, {16'd0, bus_exp});
        end
        pulse_ack(32'h0);
        sb.push_back(8'h4B); recv_all(0);

        // Read with backpressure between bytes
        send_byte(8'h52); send_byte(8'h10); send_byte(8'h00); send_byte(8'h0F);
        wait_stb();
        check("r_bus_fields", {50'd0, o_stb_brg, o_wen_brg, o_adr_brg, o_sel_brg}, {50'd0, 1'b1, 1'b0, 10'h010, 4'hF});
        @(negedge i_clk);
        pulse_ack(32'hCAFEF00D);
        sb.push_back(8'h0D); sb.push_back(8'hF0); sb.push_back(8'hFE); sb.push_back(8'hCA);
        recv_all(5);

        // Ack outside a transaction is ignored
        pulse_ack(32'h11111111);
        check("stray_ack_no_tx", {62'd0, o_tx_valid, o_rx_ready}, {62'd0, 2'b01});

        // Read with no ack times out after exactly TIMEOUT strobe cycles
        send_byte(8'h52); send_byte(8'hFF); send_byte(8'h03); send_byte(8'h0F);
        wait_stb();
        check("tmo_adr", {54'd0, o_adr_brg}, {54'd0, 10'h3FF});
        cnt = 0;
        while (o_stb_brg && cnt < 100) begin
            cnt++;
            @(negedge i_clk);
        end
        check("tmo_stb_cycles", 64'(cnt), 64'd16);
        sb.push_back(8'hEE); recv_all(0);
        send_byte(8'h00); sb.push_back(8'h3F); recv_all(0);

        // Reset on the third strobe cycle
        send_byte(8'h52); send_byte(8'h20); send_byte(8'h00); send_byte(8'h0F);
        wait_stb();
        repeat (2) @(negedge i_clk);
        check("pre_rst_stb", {63'd0, o_stb_brg}, 64'd1);
        i_rst = 1'b1;
        @(posedge i_clk);
        #1 i_rst = 1'b0;
        @(negedge i_clk);
        check("mid_rst_state", {60'd0, o_stb_brg, o_host_mode, o_rx_ready, o_tx_valid}, {60'd0, 4'b0110});

        // A following read completes normally
        send_byte(8'h52); send_byte(8'h20); send_byte(8'h00); send_byte(8'h0F);
        wait_stb();
        check("post_rst_adr", {54'd0, o_adr_brg}, {54'd0, 10'h020});
        pulse_ack(32'h01020304);
        sb.push_back(8'h04); sb.push_back(8'h03); sb.push_back(8'h02); sb.push_back(8'h01);
        recv_all(1);
        @(negedge i_clk);
        check("end_idle", {62'd0, o_rx_ready, o_tx_valid}, {62'd0, 2'b10});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/serving_host_loader.md
Name: serving_host_loader

Overview:
- Byte-stream command engine that lets a host program and inspect serving's RAM through the bridge port (adr_brg/data_brg/stb_brg/wen_brg/sel_brg/rdt_brg/ack_brg).
- Sits directly upstream of serving. It owns the RAM mux selects and holds the CPU in reset while the host owns memory.
- Consumes command bytes (e.g. from a UART RX) and emits response bytes (e.g. to a UART TX).

Parameters:
- TIMEOUT, 1024, bridge cycles to wait for ack_brg before aborting a transaction (counter width $clog2(TIMEOUT+1)).
- BOOT_HOLD, 1, 1 = come out of reset in host mode with the CPU held; 0 = come out of reset with the CPU running.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_rx_data  in  8  command byte
- i_rx_valid  in  1  command byte valid
- o_rx_ready  out  1  byte accepted when valid&ready
- o_tx_data  out  8  response byte
- o_tx_valid  out  1  response byte valid
- i_tx_ready  in  1  response byte taken when valid&ready
- o_adr_brg  out  10  word address to serving
- o_data_brg  out  32  write data
- o_stb_brg  out  1  bridge strobe
- o_wen_brg  out  1  bridge write enable
- o_sel_brg  out  4  byte select
- i_rdt_brg  in  32  read data
- i_ack_brg  in  1  bridge ack, single-cycle pulse
- o_sel_wadr, o_sel_wdata, o_sel_radr, o_sel_wen  out  1 each  =host_mode
- o_sel_rdata  out  1  =~host_mode (0 routes RAM read data to the bridge)
- o_cpu_rst  out  1  =i_rst | host_mode
- o_host_mode  out  1  status

Behaviour:
- Reset values:
  - host_mode=BOOT_HOLD.
  - State IDLE.
  - o_stb_brg, o_wen_brg, o_tx_valid = 0.
  - o_adr_brg, o_data_brg, o_sel_brg, o_tx_data = 0.
  - o_rx_ready=1.
  - Timeout counter 0.
- Command format (multi-byte fields little-endian):
  - 'W'(0x57) A0 A1 D0 D1 D2 D3 S: write. Address = {A1,A0}[9:0]; A1[7:2] ignored. Data = {D3,D2,D1,D0}. Sel = S[3:0].
  - 'R'(0x52) A0 A1 S: read.
  - 'H'(0x48): host_mode=1.
  - 'G'(0x47): host_mode=0.
- States: IDLE, ADR(2 bytes), DAT(4 bytes), SEL(1 byte), BUS, RESP. Byte counter 0..3.
- o_rx_ready=1 only in IDLE/ADR/DAT/SEL; one byte is consumed per valid&ready cycle.
- IDLE transitions:
  - 'W' or 'R' → ADR.
  - 'H' or 'G' → update host_mode next cycle, then RESP with 'K'(0x4B).
  - Any other byte → RESP with '?'(0x3F).
- W and R when host_mode=0: parse all bytes, skip BUS, respond 'E'(0x45).
- BUS:
  - o_stb_brg=1; o_wen_brg=1 for W, 0 for R.
  - Address/data/sel held stable from entry until ack; no other bus output changes while stb is high.
  - The downstream may take several cycles (sel=4'b1111 is sequenced bytewise); the loader simply waits.
  - On the i_ack_brg cycle:
    - o_stb_brg drops to 0 next cycle.
    - For R, capture i_rdt_brg in the same cycle.
    - Go to RESP.
  - Minimum one idle cycle with stb=0 between consecutive transactions.
- Timeout:
  - Counter increments each BUS cycle and clears on BUS entry.
  - At TIMEOUT: drop stb and respond 0xEE (single byte, even for R).
- RESP:
  - W → 'K'.
  - R → 4 bytes, rdt[7:0] first.
  - o_tx_valid held with stable data until i_tx_ready; then advance byte; return to IDLE after the last byte.
  - No byte drop under any backpressure.
- ack outside BUS: ignored.
- Reset mid-transaction (any state): stb drops in the next cycle, partial command discarded, host_mode returns to BOOT_HOLD.
- 'G' while a command is still parsing is impossible: it is only decoded in IDLE.

Decomposition:
- Package serving_host_pkg:
  - Opcode constants OP_W, OP_R, OP_H, OP_G.
  - Response constants RSP_OK, RSP_ERR, RSP_UNK, RSP_TMO.
  - State enum.
- One natural sub-module: serving_host_txser, the 4-byte response serializer with valid/ready.

Test Plan:
- Reset with BOOT_HOLD=1 → o_cpu_rst=1, o_sel_wadr=1, o_sel_rdata=0, stb=0. Then 'G' → 'K'; o_cpu_rst=0, o_sel_rdata=1.
- 'W' 10 00 78 56 34 12 0F → stb with adr=0x010, data=0x12345678, sel=4'hF, wen=1 held until ack (ack delayed 9 cycles) → single 'K'.
- 'R' 10 00 0F with i_rdt_brg=0xCAFEF00D at ack → bytes 0D F0 FE CA. Hold i_tx_ready low 5 cycles between bytes → no loss or reorder.
- 'R' 3FF with no ack, TIMEOUT=16 → stb high exactly 16 cycles, then response 0xEE, then back in IDLE accepting bytes.
- 'W' sent in CPU mode (after 'G') → no stb ever asserted, response 'E'. Byte 0x00 in IDLE → '?'.
- Assert i_rst during BUS (cycle 3 of stb) → stb 0 next cycle, host_mode=BOOT_HOLD, the following 'R' completes normally.
